// File: rtl/adc_ring_ram.sv
// adc_ring_ram: single-clock word RAM shared between a CPU port and NUM_CH
// ADC sample streams. Each channel owns an equal, contiguous region of the
// RAM and fills it as a ring buffer. A round-robin arbiter admits at most
// one sample per cycle. A CPU write that hits the same word as the admitted
// sample is dropped, and that drop is flagged one cycle later.
module adc_ring_ram #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int DEPTH         = 4096,
  parameter int NUM_CH        = 4,
  localparam int REGION       = DEPTH / NUM_CH,
  localparam int PTR_W        = $clog2(REGION)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wEn,
  input  logic [ADDRESS_WIDTH-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]        dataIn,
  output logic [DATA_WIDTH-1:0]        dataOut,
  input  logic [NUM_CH-1:0]            adc_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] adc_data,
  output logic [NUM_CH-1:0]            adc_ready,
  input  logic [NUM_CH-1:0]            clear_wrap,
  output logic [NUM_CH-1:0]            wrap_flag,
  output logic [NUM_CH*PTR_W-1:0]      wr_ptr,
  output logic                         cpu_collision
);

  // Channel index width; a single-channel build still needs a 1-bit index.
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  logic [CH_W-1:0]          rr_ptr;
  logic [PTR_W-1:0]         ptr_q [NUM_CH];
  logic [NUM_CH-1:0]        wrap_q;

  logic                     grant_any;
  logic [CH_W-1:0]          grant_idx;
  logic [CH_W-1:0]          cand;
  logic [PTR_W-1:0]         cur_ptr;
  logic [ADDRESS_WIDTH-1:0] adc_addr;
  logic [DATA_WIDTH-1:0]    adc_sample;
  logic                     xfer;
  logic                     collide;
  logic                     cpu_we;

  // (base + k) mod NUM_CH, used for both the arbiter search and the rr_ptr advance.
  function automatic logic [CH_W-1:0] ch_wrap(input logic [CH_W-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NUM_CH;
    return CH_W'(s);
  endfunction

  // Round-robin search: the first valid channel at or after rr_ptr, wrapping around.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = ch_wrap(rr_ptr, k);
      if (!grant_any && adc_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Ready is a one-hot of the winner, held low while reset is asserted.
  always_comb begin
    adc_ready = '0;
    if (grant_any && reset_n) begin
      adc_ready[grant_idx] = 1'b1;
    end
  end

  // Write side of the granted sample: its data, its target word, and whether it hits the CPU write.
  always_comb begin
    cur_ptr    = ptr_q[grant_idx];
    adc_sample = adc_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    adc_addr   = ADDRESS_WIDTH'(int'(grant_idx) * REGION + int'(cur_ptr));
    xfer       = grant_any && reset_n;
    collide    = xfer && wEn && (addr == adc_addr);
    cpu_we     = wEn && reset_n && !collide;
  end

  // Flatten the per-channel write pointers onto the output bus.
  always_comb begin
    wr_ptr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_ptr[i*PTR_W +: PTR_W] = ptr_q[i];
    end
  end

  assign wrap_flag = wrap_q;

  // RAM array: no reset, so both write ports are qualified by reset_n upstream.
  always_ff @(posedge clk) begin
    if (cpu_we) begin
      mem[addr] <= dataIn;
    end
    if (xfer) begin
      mem[adc_addr] <= adc_sample;
    end
  end

  // Read register, arbiter pointer, ring pointers, wrap flags and collision pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dataOut       <= '0;
      rr_ptr        <= '0;
      cpu_collision <= 1'b0;
      wrap_q        <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ptr_q[i] <= '0;
      end
    end else begin
      dataOut       <= mem[addr];
      cpu_collision <= collide;
      if (xfer) begin
        rr_ptr <= ch_wrap(grant_idx, 1);
      end
      for (int i = 0; i < NUM_CH; i++) begin
        // REGION is a power of two, so the increment wraps to 0 on its own.
        if (xfer && grant_idx == CH_W'(i)) begin
          ptr_q[i] <= ptr_q[i] + 1'b1;
        end
        // Setting the flag takes priority over a clear in the same cycle.
        if (xfer && grant_idx == CH_W'(i) && ptr_q[i] == PTR_W'(REGION - 1)) begin
          wrap_q[i] <= 1'b1;
        end else if (clear_wrap[i]) begin
          wrap_q[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/adc_ring_ram.md
ADC_RING_RAM -- requirements
Module: adc_ring_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 12, CPU address width.
REQ-003 SHALL have parameter DEPTH, default 4096, total words; DEPTH = 2**ADDRESS_WIDTH.
REQ-004 SHALL have parameter NUM_CH, default 4, ADC channel count; power of two, 1..16.
REQ-005 SHALL have derived localparam REGION = DEPTH/NUM_CH words per channel; PTR_W = log2(REGION).
REQ-006 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port wEn  input  1  CPU write enable.
REQ-009 SHALL have port addr  input  ADDRESS_WIDTH  CPU word address.
REQ-010 SHALL have port dataIn  input  DATA_WIDTH  CPU write data.
REQ-011 SHALL have port dataOut  output  DATA_WIDTH  registered CPU read data.
REQ-012 SHALL have port adc_valid  input  NUM_CH  per-channel sample offered.
REQ-013 SHALL have port adc_data  input  NUM_CH*DATA_WIDTH  samples; channel i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 SHALL have port adc_ready  output  NUM_CH  one-hot grant; transfer when valid&ready.
REQ-015 SHALL have port clear_wrap  input  NUM_CH  per-channel clear of wrap_flag.
REQ-016 SHALL have port wrap_flag  output  NUM_CH  sticky: channel region has wrapped.
REQ-017 SHALL have port wr_ptr  output  NUM_CH*PTR_W  next write offset per channel, channel i in [i*PTR_W +: PTR_W].
REQ-018 SHALL have port cpu_collision  output  1  one-cycle pulse: CPU write dropped.

Function
REQ-019 SHALL store memory as DEPTH x DATA_WIDTH array; channel i owns addresses i*REGION .. i*REGION+REGION-1.
REQ-020 SHALL perform CPU write memory[addr] <= dataIn on rising edge when wEn=1.
REQ-021 SHALL register dataOut <= memory[addr] every cycle; latency 1; read-during-write returns old data.
REQ-022 SHALL accept at most one ADC sample per cycle, chosen by round-robin over asserted adc_valid bits.
REQ-023 SHALL derive adc_ready combinationally: highest-priority valid channel starting from rr_ptr, wrapping; zero when no valid or reset_n=0.
REQ-024 SHALL, on transfer from channel g, write adc_data[g] to memory[g*REGION + wr_ptr[g]] and advance rr_ptr to (g+1) mod NUM_CH.
REQ-025 SHALL leave rr_ptr unchanged in cycles with no transfer.
REQ-026 SHALL increment wr_ptr[g] by 1 per transfer; from REGION-1 it wraps to 0 and sets wrap_flag[g].
REQ-027 SHALL clear wrap_flag[i] on clear_wrap[i]=1; simultaneous set and clear: set wins.
REQ-028 SHALL, when CPU write and ADC transfer hit the same address in one cycle, store ADC data, drop CPU write, pulse cpu_collision next cycle.
REQ-029 SHALL allow CPU write and ADC transfer to different addresses in the same cycle; both complete.
REQ-030 SHALL keep adc_valid/adc_data holding required of source until ready; dropping valid without ready loses nothing.
REQ-031 SHALL ignore CPU writes into ADC regions only for collisions; non-colliding CPU writes anywhere succeed.

Reset
REQ-032 SHALL, while reset_n=0, asynchronously force dataOut=0, wr_ptr all 0, wrap_flag all 0, rr_ptr=0, cpu_collision=0.
REQ-033 SHALL NOT initialise memory contents on reset; no write of either port occurs on an edge with reset_n=0.
REQ-034 SHALL restart arbitration at channel 0 after reset release; a transfer pending at reset assertion is discarded.

Verification
REQ-035 SHALL cover: reset, CPU write 0xDEADBEEF to addr 5, read addr 5 -> dataOut=0xDEADBEEF one cycle after read.
REQ-036 SHALL cover: adc_valid=4'b1111 held 8 cycles -> grants ch0,1,2,3,0,1,2,3; each wr_ptr=2.
REQ-037 SHALL cover: 1024 ch2 transfers -> wr_ptr[2]=0, wrap_flag[2]=1, 1025th writes addr 2048; clear_wrap[2] -> flag 0.
REQ-038 SHALL cover: CPU write 0x1111 to addr 1024 same cycle as ch1 sample 0x2222 at wr_ptr 0 -> memory[1024]=0x2222, cpu_collision pulses once.
REQ-039 SHALL cover: reset_n low mid-stream with ch3 valid -> all outputs zero immediately; after release first grant is lowest valid channel from 0.
REQ-040 SHALL cover: NUM_CH=1, DEPTH=16 build -> every cycle with valid granted, wrap after 16 samples.
